// File: rtl/dcache_store_port_arbiter.sv
// dcache_store_port_arbiter
//
// Owns the single write port of the L1 data-cache data SRAM and shares it between
// the store buffer's non-speculative drain and the line-refill engine.
//   - Store hits are written into the cache after a one-cycle tag lookup.
//   - Store misses are written around to the memory bus (no write-allocate).
//   - Refill bursts are atomic: once started, no store is accepted until the last beat.
//   - A fence is acknowledged while idle with nothing non-speculative left to drain.
//
// Optional feature (compile-time macro SDRAIN_STARVE_GUARD_EN):
//   defined   - a 2-bit saturating counter tracks refill bursts that started while a store
//               was waiting; once it reaches STARVE_MAX the store wins arbitration in idle.
//   undefined - the refill always wins arbitration and the counter is absent.
//
// Ports:
//   cpu_clk_i, cpu_rst_ni            clock, asynchronous active-low reset
//   store_*_i, cache_done_o          store drain request (held until done) and retire pulse
//   no_nonspec_i, fence_req_i,
//   fence_done_o                     fence handshake
//   refill_*_i, refill_ready_o       refill beats and per-beat acceptance
//   lkp_*                            tag lookup request and hit result one cycle later
//   wr_*_o                           data SRAM write port
//   bus_*                            write-around request, held until bus_ack_i
module dcache_store_port_arbiter #(
  parameter int unsigned PHYS       = 32,
  parameter int unsigned WAYS_W     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              cpu_clk_i,
  input  logic              cpu_rst_ni,
  // store buffer drain
  input  logic              store_valid_i,
  input  logic [PHYS-3:0]   store_address_i,
  input  logic [31:0]       store_data_i,
  input  logic [3:0]        store_bm_i,
  output logic              cache_done_o,
  // fence
  input  logic              no_nonspec_i,
  input  logic              fence_req_i,
  output logic              fence_done_o,
  // refill engine
  input  logic              refill_valid_i,
  input  logic [PHYS-3:0]   refill_address_i,
  input  logic [31:0]       refill_data_i,
  input  logic [WAYS_W-1:0] refill_way_i,
  input  logic              refill_last_i,
  output logic              refill_ready_o,
  // tag lookup
  output logic              lkp_valid_o,
  output logic [PHYS-3:0]   lkp_address_o,
  input  logic              lkp_hit_i,
  input  logic [WAYS_W-1:0] lkp_way_i,
  // data SRAM write port
  output logic              wr_en_o,
  output logic [PHYS-3:0]   wr_address_o,
  output logic [31:0]       wr_data_o,
  output logic [3:0]        wr_bm_o,
  output logic [WAYS_W-1:0] wr_way_o,
  // write-around bus
  output logic              bus_req_o,
  output logic [PHYS-3:0]   bus_address_o,
  output logic [31:0]       bus_data_o,
  output logic [3:0]        bus_bm_o,
  input  logic              bus_ack_i
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StHitChk,
    StWrite,
    StBus,
    StHold,
    StRefill
  } state_e;

  state_e              state_q, state_d;
  logic [PHYS-3:0]     st_addr_q, st_addr_d;
  logic [31:0]         st_data_q, st_data_d;
  logic [3:0]          st_bm_q, st_bm_d;
  logic [WAYS_W-1:0]   st_way_q, st_way_d;
  logic                take_store;

`ifdef SDRAIN_STARVE_GUARD_EN
  logic [1:0] starve_q, starve_d;

  // A store wins in idle only when refills have starved it long enough.
  assign take_store = store_valid_i & (~refill_valid_i | (starve_q == 2'(STARVE_MAX)));

  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (take_store) begin
        starve_d = 2'd0;
      end else if (refill_valid_i && store_valid_i && (starve_q != 2'd3)) begin
        starve_d = starve_q + 2'd1;
      end
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign take_store = store_valid_i & ~refill_valid_i;

  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
`endif

  always_comb begin
    state_d        = state_q;
    st_addr_d      = st_addr_q;
    st_data_d      = st_data_q;
    st_bm_d        = st_bm_q;
    st_way_d       = st_way_q;
    cache_done_o   = 1'b0;
    fence_done_o   = 1'b0;
    refill_ready_o = 1'b0;
    lkp_valid_o    = 1'b0;
    lkp_address_o  = '0;
    wr_en_o        = 1'b0;
    wr_address_o   = '0;
    wr_data_o      = '0;
    wr_bm_o        = '0;
    wr_way_o       = '0;
    bus_req_o      = 1'b0;
    bus_address_o  = '0;
    bus_data_o     = '0;
    bus_bm_o       = '0;

    unique case (state_q)
      StIdle: begin
        fence_done_o = fence_req_i & no_nonspec_i & ~store_valid_i;
        if (take_store) begin
          state_d   = StLookup;
          st_addr_d = store_address_i;
          st_data_d = store_data_i;
          st_bm_d   = store_bm_i;
        end else if (refill_valid_i) begin
          state_d = StRefill;
        end
      end
      StLookup: begin
        lkp_valid_o   = 1'b1;
        lkp_address_o = st_addr_q;
        state_d       = StHitChk;
      end
      StHitChk: begin
        if (lkp_hit_i) begin
          st_way_d = lkp_way_i;
          state_d  = StWrite;
        end else begin
          state_d = StBus;
        end
      end
      StWrite: begin
        wr_en_o      = 1'b1;
        wr_address_o = st_addr_q;
        wr_data_o    = st_data_q;
        wr_bm_o      = st_bm_q;
        wr_way_o     = st_way_q;
        cache_done_o = 1'b1;
        state_d      = StHold;
      end
      StBus: begin
        bus_req_o     = 1'b1;
        bus_address_o = st_addr_q;
        bus_data_o    = st_data_q;
        bus_bm_o      = st_bm_q;
        if (bus_ack_i) begin
          cache_done_o = 1'b1;
          state_d      = StHold;
        end
      end
      StHold: begin
        // The store buffer drops store_valid one cycle after cache_done; skip that stale cycle.
        state_d = StIdle;
      end
      StRefill: begin
        refill_ready_o = 1'b1;
        if (refill_valid_i) begin
          wr_en_o      = 1'b1;
          wr_address_o = refill_address_i;
          wr_data_o    = refill_data_i;
          wr_bm_o      = 4'hF;
          wr_way_o     = refill_way_i;
          if (refill_last_i) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      state_q   <= StIdle;
      st_addr_q <= '0;
      st_data_q <= '0;
      st_bm_q   <= '0;
      st_way_q  <= '0;
    end else begin
      state_q   <= state_d;
      st_addr_q <= st_addr_d;
      st_data_q <= st_data_d;
      st_bm_q   <= st_bm_d;
      st_way_q  <= st_way_d;
    end
  end

endmodule

// File: tb/tb_dcache_store_port_arbiter.sv
// Directed, table-driven bench for dcache_store_port_arbiter. Each table row is one clock
// cycle: inputs applied after the falling edge, outputs compared 1 ns later.
module tb_dcache_store_port_arbiter;

  localparam int unsigned AW = 30;
  localparam logic [AW-1:0] ST_ADDR = 30'h100;
  localparam logic [31:0]   ST_DATA = 32'hDEADBEEF;
  localparam logic [3:0]    ST_BM   = 4'b0011;

`ifdef SDRAIN_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          store_valid_i;
  logic [AW-1:0] store_address_i;
  logic [31:0]   store_data_i;
  logic [3:0]    store_bm_i;
  logic          cache_done_o;
  logic          no_nonspec_i;
  logic          fence_req_i;
  logic          fence_done_o;
  logic          refill_valid_i;
  logic [AW-1:0] refill_address_i;
  logic [31:0]   refill_data_i;
  logic          refill_way_i;
  logic          refill_last_i;
  logic          refill_ready_o;
  logic          lkp_valid_o;
  logic [AW-1:0] lkp_address_o;
  logic          lkp_hit_i;
  logic          lkp_way_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_address_o;
  logic [31:0]   wr_data_o;
  logic [3:0]    wr_bm_o;
  logic          wr_way_o;
  logic          bus_req_o;
  logic [AW-1:0] bus_address_o;
  logic [31:0]   bus_data_o;
  logic [3:0]    bus_bm_o;
  logic          bus_ack_i;

  dcache_store_port_arbiter #(
    .PHYS       (32),
    .WAYS_W     (1),
    .STARVE_MAX (3)
  ) dut (
    .cpu_clk_i        (clk),
    .cpu_rst_ni       (rst_n),
    .store_valid_i    (store_valid_i),
    .store_address_i  (store_address_i),
    .store_data_i     (store_data_i),
    .store_bm_i       (store_bm_i),
    .cache_done_o     (cache_done_o),
    .no_nonspec_i     (no_nonspec_i),
    .fence_req_i      (fence_req_i),
    .fence_done_o     (fence_done_o),
    .refill_valid_i   (refill_valid_i),
    .refill_address_i (refill_address_i),
    .refill_data_i    (refill_data_i),
    .refill_way_i     (refill_way_i),
    .refill_last_i    (refill_last_i),
    .refill_ready_o   (refill_ready_o),
    .lkp_valid_o      (lkp_valid_o),
    .lkp_address_o    (lkp_address_o),
    .lkp_hit_i        (lkp_hit_i),
    .lkp_way_i        (lkp_way_i),
    .wr_en_o          (wr_en_o),
    .wr_address_o     (wr_address_o),
    .wr_data_o        (wr_data_o),
    .wr_bm_o          (wr_bm_o),
    .wr_way_o         (wr_way_o),
    .bus_req_o        (bus_req_o),
    .bus_address_o    (bus_address_o),
    .bus_data_o       (bus_data_o),
    .bus_bm_o         (bus_bm_o),
    .bus_ack_i        (bus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in: {sv, rv, rlast, hit, way, ack, fence_req, no_nonspec}
  // ex: {wr_en, cache_done, lkp_valid, bus_req, refill_ready, fence_done}
  typedef struct {
    logic [7:0]    in;
    logic [5:0]    ex;
    logic [AW-1:0] ra;
    logic [31:0]   rd;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [3:0]    ebm;
    logic          ew;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  always @(posedge clk) if (cache_done_o) done_cnt++;

  task automatic add(input logic [7:0] in, input logic [5:0] ex, input logic [AW-1:0] ra,
                     input logic [31:0] rd, input logic [AW-1:0] ea, input logic [31:0] ed,
                     input logic [3:0] ebm, input logic ew);
    vec_t v;
    v.in = in; v.ex = ex; v.ra = ra; v.rd = rd;
    v.ea = ea; v.ed = ed; v.ebm = ebm; v.ew = ew;
    vecs.push_back(v);
  endtask

  task automatic addc(input logic [7:0] in, input logic [5:0] ex);
    add(in, ex, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic drive(input logic [7:0] in, input logic [AW-1:0] ra, input logic [31:0] rd);
    store_valid_i    = in[7];
    refill_valid_i   = in[6];
    refill_last_i    = in[5];
    lkp_hit_i        = in[4];
    lkp_way_i        = in[3];
    refill_way_i     = in[3];
    bus_ack_i        = in[2];
    fence_req_i      = in[1];
    no_nonspec_i     = in[0];
    refill_address_i = ra;
    refill_data_i    = rd;
  endtask

  task automatic chk(input string name, input int idx, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  function automatic logic [5:0] ctrl();
    return {wr_en_o, cache_done_o, lkp_valid_o, bus_req_o, refill_ready_o, fence_done_o};
  endfunction

  function automatic logic [255:0] all_out();
    return {87'd0, ctrl(), lkp_address_o, wr_address_o, wr_data_o, wr_bm_o, wr_way_o,
            bus_address_o, bus_data_o, bus_bm_o};
  endfunction

  initial begin
    bit seen;
    bit granted;
    int snap;

    rst_n           = 1'b0;
    store_address_i = ST_ADDR;
    store_data_i    = ST_DATA;
    store_bm_i      = ST_BM;
    drive(8'h00, '0, '0);

    // Store hit, stale store_valid during HOLD
    addc(8'b1000_0000, 6'b000000);
    addc(8'b1000_0000, 6'b001000);
    addc(8'b1001_1000, 6'b000000);
    add (8'b1000_0000, 6'b110000, '0, '0, ST_ADDR, ST_DATA, ST_BM, 1'b1);
    addc(8'b1000_0000, 6'b000000);
    addc(8'b0000_0000, 6'b000000);
    // Store miss, ack after 5 cycles of bus_req
    addc(8'b1000_0000, 6'b000000);
    addc(8'b1000_0000, 6'b001000);
    addc(8'b1000_0000, 6'b000000);
    for (int i = 0; i < 5; i++) addc(8'b1000_0000, 6'b000100);
    addc(8'b1000_0100, 6'b010100);
    addc(8'b1000_0000, 6'b000000);
    addc(8'b0000_0000, 6'b000000);
    // 4-beat refill with a gap after beat 2, store waiting throughout
    add (8'b1100_1000, 6'b000000, 30'h200, 32'hA0, '0, '0, '0, 1'b0);
    add (8'b1100_1000, 6'b100010, 30'h200, 32'hA0, 30'h200, 32'hA0, 4'hF, 1'b1);
    add (8'b1100_1000, 6'b100010, 30'h201, 32'hA1, 30'h201, 32'hA1, 4'hF, 1'b1);
    addc(8'b1000_1000, 6'b000010);
    add (8'b1100_1000, 6'b100010, 30'h202, 32'hA2, 30'h202, 32'hA2, 4'hF, 1'b1);
    add (8'b1110_1000, 6'b100010, 30'h203, 32'hA3, 30'h203, 32'hA3, 4'hF, 1'b1);
    addc(8'b1000_0000, 6'b000000);
    addc(8'b1000_0000, 6'b001000);
    addc(8'b1001_0000, 6'b000000);
    add (8'b1000_0000, 6'b110000, '0, '0, ST_ADDR, ST_DATA, ST_BM, 1'b0);
    addc(8'b1000_0000, 6'b000000);
    addc(8'b0000_0000, 6'b000000);
    // Store and refill both valid in HOLD: refill taken in the next idle cycle
    addc(8'b1000_0000, 6'b000000);
    addc(8'b1000_0000, 6'b001000);
    addc(8'b1001_1000, 6'b000000);
    add (8'b1000_0000, 6'b110000, '0, '0, ST_ADDR, ST_DATA, ST_BM, 1'b1);
    add (8'b1100_0000, 6'b000000, 30'h300, 32'hB0, '0, '0, '0, 1'b0);
    add (8'b0100_0000, 6'b000000, 30'h300, 32'hB0, '0, '0, '0, 1'b0);
    add (8'b0110_0000, 6'b100010, 30'h300, 32'hB0, 30'h300, 32'hB0, 4'hF, 1'b0);
    addc(8'b0000_0000, 6'b000000);
    // Fence held while a store drains; no_nonspec rises after cache_done
    addc(8'b1000_0010, 6'b000000);
    addc(8'b1000_0010, 6'b001000);
    addc(8'b1001_0010, 6'b000000);
    add (8'b1000_0010, 6'b110000, '0, '0, ST_ADDR, ST_DATA, ST_BM, 1'b0);
    addc(8'b1000_0011, 6'b000000);
    addc(8'b0000_0011, 6'b000001);
    addc(8'b0000_0011, 6'b000001);
    addc(8'b0000_0000, 6'b000000);

    // Reset state
    #12;
    chk("reset outputs", 0, all_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset outputs", 0, all_out(), '0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].in, vecs[i].ra, vecs[i].rd);
      #1;
      chk("ctrl", i, {250'd0, ctrl()}, {250'd0, vecs[i].ex});
      if (vecs[i].ex[5])
        chk("wr payload", i, {wr_address_o, wr_data_o, wr_bm_o, wr_way_o},
            {vecs[i].ea, vecs[i].ed, vecs[i].ebm, vecs[i].ew});
      if (vecs[i].ex[3]) chk("lkp addr", i, {226'd0, lkp_address_o}, {226'd0, ST_ADDR});
      if (vecs[i].ex[2])
        chk("bus payload", i, {bus_address_o, bus_data_o, bus_bm_o}, {ST_ADDR, ST_DATA, ST_BM});
      @(negedge clk);
    end

    // Reset in the middle of a bus write-around
    drive(8'b1000_0000, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    chk("bus before reset", 0, {255'd0, bus_req_o}, {255'd0, 1'b1});
    snap = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("outputs in reset mid-bus", 0, all_out(), '0);
    drive(8'b0000_0000, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(8'b0000_0011, '0, '0);
    #1;
    chk("idle after reset (fence)", 0, {255'd0, fence_done_o}, {255'd0, 1'b1});
    chk("no done for abandoned store", 0, done_cnt, snap);
    @(negedge clk);
    drive(8'b0000_0000, '0, '0);
    @(negedge clk);

    // Store waits while single-beat refills are requested back to back
    granted = 1'b0;
    drive(8'b1111_0000, 30'h400, 32'hC0);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("starve idle", b, {250'd0, ctrl()}, '0);
      @(negedge clk);
      #1;
      if (GUARD && b == 3) begin
        chk("starve grant", b, {lkp_valid_o, refill_ready_o}, 2'b10);
        granted = 1'b1;
      end else begin
        chk("starve grant", b, {lkp_valid_o, refill_ready_o}, 2'b01);
      end
      @(negedge clk);
      if (granted) break;
    end
    drive(8'b1001_0000, '0, '0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (cache_done_o) seen = 1'b1;
      @(negedge clk);
    end
    chk("starve store retired", 0, {255'd0, seen}, {255'd0, 1'b1});
    drive(8'b0000_0000, '0, '0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
